// File: rtl/hit_event_handler.sv
// hit_event_handler: turns collision hit pulses into lives, cooldown and game over.
// Ports: clk, resetN (async low), startOfFrame, hitPulse, restart in;
//        lives, lifeLostPulse, inCooldown, blinkHide, gameOver, ignoredHits out.
module hit_event_handler #(
    parameter int LIVES_INIT      = 3,
    parameter int LIVES_W         = 3,
    parameter int COOLDOWN_FRAMES = 45,
    parameter int BLINK_PERIOD    = 4,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               resetN,
    input  logic               startOfFrame,
    input  logic               hitPulse,
    input  logic               restart,
    output logic [LIVES_W-1:0] lives,
    output logic               lifeLostPulse,
    output logic               inCooldown,
    output logic               blinkHide,
    output logic               gameOver,
    output logic [CNT_W-1:0]   ignoredHits
);

    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        COOLDOWN = 2'd1,
        OVER     = 2'd2
    } state_t;

    localparam logic [LIVES_W-1:0] LIVES_RST = LIVES_W'(LIVES_INIT);
    localparam logic [CNT_W-1:0]   CD_LOAD   = CNT_W'(COOLDOWN_FRAMES);
    localparam logic [CNT_W-1:0]   BLINK_TOP = CNT_W'(BLINK_PERIOD - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
    localparam logic [CNT_W-1:0]   CNT_ONE   = CNT_W'(1);
    localparam logic [LIVES_W-1:0] LIVES_ONE = LIVES_W'(1);

    state_t             state;
    state_t             state_nxt;
    logic [LIVES_W-1:0] lives_nxt;
    logic [CNT_W-1:0]   frame_cnt;
    logic [CNT_W-1:0]   frame_nxt;
    logic [CNT_W-1:0]   blink_cnt;
    logic [CNT_W-1:0]   blink_nxt;
    logic               hide_nxt;
    logic               pulse_nxt;
    logic [CNT_W-1:0]   ign_nxt;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state         <= PLAY;
            lives         <= LIVES_RST;
            frame_cnt     <= '0;
            blink_cnt     <= '0;
            blinkHide     <= 1'b0;
            lifeLostPulse <= 1'b0;
            ignoredHits   <= '0;
        end else begin
            state         <= state_nxt;
            lives         <= lives_nxt;
            frame_cnt     <= frame_nxt;
            blink_cnt     <= blink_nxt;
            blinkHide     <= hide_nxt;
            lifeLostPulse <= pulse_nxt;
            ignoredHits   <= ign_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        lives_nxt = lives;
        frame_nxt = frame_cnt;
        blink_nxt = blink_cnt;
        hide_nxt  = blinkHide;
        pulse_nxt = 1'b0;
        ign_nxt   = ignoredHits;
        if (restart) begin
            state_nxt = PLAY;
            lives_nxt = LIVES_RST;
            frame_nxt = '0;
            blink_nxt = '0;
            hide_nxt  = 1'b0;
            ign_nxt   = '0;
        end else begin
            unique case (state)
                PLAY: begin
                    if (hitPulse) begin
                        pulse_nxt = 1'b1;
                        // lives==0 cannot occur in PLAY; <=1 keeps underflow impossible
                        if (lives <= LIVES_ONE) begin
                            state_nxt = OVER;
                            lives_nxt = '0;
                            hide_nxt  = 1'b0;
                        end else begin
                            state_nxt = COOLDOWN;
                            lives_nxt = lives - LIVES_ONE;
                            frame_nxt = CD_LOAD;
                            blink_nxt = '0;
                            hide_nxt  = 1'b1;
                        end
                    end
                end
                COOLDOWN: begin
                    if (hitPulse && ignoredHits != CNT_MAX) begin
                        ign_nxt = ignoredHits + CNT_ONE;
                    end
                    if (startOfFrame) begin
                        frame_nxt = frame_cnt - CNT_ONE;
                        if (frame_cnt == CNT_ONE) begin
                            state_nxt = PLAY;
                            hide_nxt  = 1'b0;
                            blink_nxt = '0;
                        end else if (blink_cnt == BLINK_TOP) begin
                            blink_nxt = '0;
                            hide_nxt  = ~blinkHide;
                        end else begin
                            blink_nxt = blink_cnt + CNT_ONE;
                        end
                    end
                end
                OVER: begin
                    lives_nxt = '0;
                    hide_nxt  = 1'b0;
                end
                default: begin
                    state_nxt = PLAY;
                end
            endcase
        end
    end

    assign inCooldown = (state == COOLDOWN);
    assign gameOver   = (state == OVER);

endmodule

// File: tb/tb_hit_event_handler.sv
// tb_hit_event_handler: scoreboard bench for hit_event_handler.
// Expected outputs are queued per stimulus cycle and compared after the edge.
module tb_hit_event_handler;

    logic       clk = 1'b0;
    logic       resetN;
    logic       startOfFrame;
    logic       hitPulse;
    logic       restart;
    logic [2:0] lives;
    logic       lifeLostPulse;
    logic       inCooldown;
    logic       blinkHide;
    logic       gameOver;
    logic [7:0] ignoredHits;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [2:0] lv;
        logic       pl;
        logic       cd;
        logic       hd;
        logic       ov;
        logic [7:0] ig;
    } obs_t;

    typedef struct packed {
        logic sof;
        logic hit;
        logic rst;
        obs_t e;
    } row_t;

    obs_t sb[$];

    hit_event_handler #(
        .LIVES_INIT(3),
        .LIVES_W(3),
        .COOLDOWN_FRAMES(4),
        .BLINK_PERIOD(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .resetN(resetN),
        .startOfFrame(startOfFrame),
        .hitPulse(hitPulse),
        .restart(restart),
        .lives(lives),
        .lifeLostPulse(lifeLostPulse),
        .inCooldown(inCooldown),
        .blinkHide(blinkHide),
        .gameOver(gameOver),
        .ignoredHits(ignoredHits)
    );

    always #5 clk = ~clk;

    function automatic obs_t mk(int l, bit p, bit c, bit h, bit o, int i);
        obs_t x;
        x.lv = 3'(l);
        x.pl = p;
        x.cd = c;
        x.hd = h;
        x.ov = o;
        x.ig = 8'(i);
        return x;
    endfunction

    function automatic row_t r(bit s, bit h, bit rs, obs_t e);
        row_t x;
        x.sof = s;
        x.hit = h;
        x.rst = rs;
        x.e   = e;
        return x;
    endfunction

    function automatic obs_t sample();
        obs_t x;
        x = {lives, lifeLostPulse, inCooldown, blinkHide, gameOver, ignoredHits};
        return x;
    endfunction

    // drives one cycle of stimulus, queues its expectation, returns observation
    task automatic apply(input row_t rw, output obs_t got);
        startOfFrame = rw.sof;
        hitPulse     = rw.hit;
        restart      = rw.rst;
        sb.push_back(rw.e);
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        hitPulse     = 1'b0;
        restart      = 1'b0;
        got = sample();
    endtask

    // cooldown of 4 frames with BLINK_PERIOD=2: hide 1,0,0 then exit
    task automatic push_cooldown(inout row_t q[$], input int l, input int ig);
        q.push_back(r(1, 0, 0, mk(l, 0, 1, 1, 0, ig)));
        q.push_back(r(1, 0, 0, mk(l, 0, 1, 0, 0, ig)));
        q.push_back(r(1, 0, 0, mk(l, 0, 1, 0, 0, ig)));
        q.push_back(r(1, 0, 0, mk(l, 0, 0, 0, 0, ig)));
    endtask

    task automatic test_reset();
        obs_t got;
        obs_t e;
        resetN       = 1'b0;
        startOfFrame = 1'b0;
        hitPulse     = 1'b0;
        restart      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        got = sample();
        e = mk(3, 0, 0, 0, 0, 0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset got=%h exp=%h", got, e);
        end
        resetN = 1'b1;
    endtask

    task automatic test_hit_blink();
        row_t q[$];
        obs_t got;
        obs_t e;
        q.push_back(r(0, 1, 0, mk(2, 1, 1, 1, 0, 0)));
        q.push_back(r(0, 0, 0, mk(2, 0, 1, 1, 0, 0)));
        push_cooldown(q, 2, 0);
        foreach (q[i]) begin
            apply(q[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL hit_blink[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_ignored();
        row_t q[$];
        obs_t got;
        obs_t e;
        q.push_back(r(0, 0, 1, mk(3, 0, 0, 0, 0, 0)));
        q.push_back(r(0, 1, 0, mk(2, 1, 1, 1, 0, 0)));
        for (int k = 1; k <= 3; k++) begin
            q.push_back(r(0, 1, 0, mk(2, 0, 1, 1, 0, k)));
            q.push_back(r(0, 0, 0, mk(2, 0, 1, 1, 0, k)));
        end
        foreach (q[i]) begin
            apply(q[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL ignored[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_coincident();
        row_t q[$];
        obs_t got;
        obs_t e;
        q.push_back(r(1, 0, 0, mk(2, 0, 1, 1, 0, 3)));
        q.push_back(r(1, 0, 0, mk(2, 0, 1, 0, 0, 3)));
        q.push_back(r(1, 0, 0, mk(2, 0, 1, 0, 0, 3)));
        q.push_back(r(1, 1, 0, mk(2, 0, 0, 0, 0, 4)));
        q.push_back(r(0, 1, 0, mk(1, 1, 1, 1, 0, 4)));
        foreach (q[i]) begin
            apply(q[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL coincident[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_game_over();
        row_t q[$];
        obs_t got;
        obs_t e;
        q.push_back(r(0, 0, 1, mk(3, 0, 0, 0, 0, 0)));
        for (int k = 0; k < 2; k++) begin
            q.push_back(r(0, 1, 0, mk(2 - k, 1, 1, 1, 0, 0)));
            push_cooldown(q, 2 - k, 0);
        end
        q.push_back(r(0, 1, 0, mk(0, 1, 0, 0, 1, 0)));
        q.push_back(r(0, 0, 0, mk(0, 0, 0, 0, 1, 0)));
        q.push_back(r(1, 1, 0, mk(0, 0, 0, 0, 1, 0)));
        q.push_back(r(0, 1, 0, mk(0, 0, 0, 0, 1, 0)));
        q.push_back(r(0, 0, 1, mk(3, 0, 0, 0, 0, 0)));
        foreach (q[i]) begin
            apply(q[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL game_over[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_restart_hit();
        row_t q[$];
        obs_t got;
        obs_t e;
        for (int k = 0; k < 2; k++) begin
            q.push_back(r(0, 1, 0, mk(2 - k, 1, 1, 1, 0, 0)));
            push_cooldown(q, 2 - k, 0);
        end
        q.push_back(r(0, 1, 1, mk(3, 0, 0, 0, 0, 0)));
        q.push_back(r(0, 0, 0, mk(3, 0, 0, 0, 0, 0)));
        foreach (q[i]) begin
            apply(q[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL restart_hit[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_saturate();
        row_t q[$];
        obs_t got;
        obs_t e;
        q.push_back(r(0, 1, 0, mk(2, 1, 1, 1, 0, 0)));
        for (int k = 1; k <= 258; k++) begin
            q.push_back(r(0, 1, 0, mk(2, 0, 1, 1, 0, (k > 255) ? 255 : k)));
        end
        foreach (q[i]) begin
            apply(q[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL saturate[%0d] got=%h exp=%h", i, got, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        obs_t got;
        obs_t e;
        // previous test leaves COOLDOWN with blinkHide=1 and ignoredHits=255
        @(negedge clk);
        resetN = 1'b0;
        #1;
        got = sample();
        e = mk(3, 0, 0, 0, 0, 0);
        checks++;
        if (got !== e) begin
            errors++;
            $display("FAIL reset_mid got=%h exp=%h", got, e);
        end
        @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    initial begin
        test_reset();
        @(posedge clk);
        #1;
        test_hit_blink();
        test_ignored();
        test_coincident();
        test_game_over();
        test_restart_hit();
        test_saturate();
        test_reset_mid();
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/hit_event_handler.md
Name: hit_event_handler

Overview:
Consumes the single-cycle per-frame hit pulse from the collision controller and turns it into game consequences. It tracks remaining lives and opens a post-hit invulnerability (cooldown) window measured in frames. During that window it produces a blink mask for the player sprite and ignores further hits. It declares game over when the last life is lost. It sits between the collision controller and the drawing/score logic in the VGA game top.

Parameters:
LIVES_INIT, 3, lives loaded at reset/restart; legal range 1..(2^LIVES_W)-1
LIVES_W, 3, width of the lives counter
COOLDOWN_FRAMES, 45, number of startOfFrame pulses the invulnerability window lasts; must be >=1
BLINK_PERIOD, 4, frames per blink half-period; must be >=1
CNT_W, 8, width of the cooldown frame counter and the ignored-hit counter

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
startOfFrame  in  1  one-cycle pulse at each frame start
hitPulse  in  1  one-cycle pulse, at most one per frame, from collision controller
restart  in  1  synchronous one-cycle request to start a new game
lives  out  LIVES_W  remaining lives
lifeLostPulse  out  1  one-cycle pulse when a hit is accepted
inCooldown  out  1  high while state is COOLDOWN
blinkHide  out  1  high = suppress player sprite drawing this frame
gameOver  out  1  high while state is OVER
ignoredHits  out  CNT_W  saturating count of hits received during COOLDOWN

Behaviour:
- Reset and clock: resetN asynchronous, active-low; clk rising edge.
- Reset values: state=PLAY, lives=LIVES_INIT, frameCnt=0, blinkCnt=0, lifeLostPulse=0, blinkHide=0, gameOver=0, ignoredHits=0.
- All outputs are registered. inCooldown and gameOver are decoded from the registered state.
- FSM states: PLAY, COOLDOWN, OVER.
- Priority: restart > hitPulse/startOfFrame processing, in every state.
- restart, in any state: next cycle state=PLAY, lives=LIVES_INIT, blinkHide=0, frameCnt=0, blinkCnt=0, ignoredHits=0, lifeLostPulse=0.
  - A hitPulse in the same cycle as restart is dropped.
- PLAY, on hitPulse (takes effect at the next edge, latency 1):
  - lives decrements by 1.
  - lifeLostPulse=1 for exactly one cycle.
  - If lives was 1: state becomes OVER, lives=0, blinkHide=0.
  - Otherwise: state becomes COOLDOWN, frameCnt=COOLDOWN_FRAMES, blinkCnt=0, blinkHide=1.
- PLAY, startOfFrame: no effect.
- COOLDOWN, hitPulse: ignored for lives. ignoredHits increments, saturating at 2^CNT_W-1. lifeLostPulse stays 0.
- COOLDOWN, each startOfFrame:
  - frameCnt decrements.
  - If frameCnt==1 before the decrement: state becomes PLAY, blinkHide=0, blinkCnt=0.
  - Otherwise blinkCnt advances: if blinkCnt==BLINK_PERIOD-1, then blinkCnt=0 and blinkHide toggles; else blinkCnt increments.
- Simultaneous hitPulse and startOfFrame in COOLDOWN:
  - Both are processed: the hit is counted as ignored and the frame is counted.
  - If that frame ends the cooldown, the hit is still ignored. A hit is only accepted when the registered state is PLAY.
- OVER: hitPulse and startOfFrame are ignored (ignoredHits unchanged). gameOver=1, lives=0. Leaves OVER only via restart.
- Lives never underflow. Decrement only occurs from PLAY with lives>=1.
- Reset mid-cooldown: everything returns immediately (asynchronously) to the reset values.

Test Plan:
- Params LIVES_INIT=3, COOLDOWN_FRAMES=4, BLINK_PERIOD=2. Release reset, pulse hitPulse -> next cycle lives=2, lifeLostPulse high 1 cycle, inCooldown=1, blinkHide=1.
- Continue from above, 4 startOfFrame pulses -> blinkHide: 1 after SOF1, 0 after SOF2, 0 after SOF3; after SOF4 inCooldown=0, blinkHide=0, state PLAY.
- In COOLDOWN, 3 hitPulses on separate cycles -> lives stays 2, ignoredHits=3, no lifeLostPulse.
- hitPulse coincident with the final cooldown startOfFrame -> lives unchanged, ignoredHits +1, state PLAY. A later hitPulse -> lives decrements.
- Three accepted hits, with cooldowns completed between them -> lives=0, gameOver=1. Further hitPulse -> no change. restart -> lives=3, gameOver=0, ignoredHits=0.
- restart and hitPulse in the same cycle during PLAY with lives=1 -> lives=3, no lifeLostPulse, gameOver=0. Separately, resetN asserted mid-cooldown -> all outputs at reset values immediately.
